approx_error_monitor: RTL and testbench
=======================================

APPROX_ERROR_MONITOR -- requirements
Module: approx_error_monitor

Interface
REQ-001 The block SHALL provide parameter W, default 32, giving the operand/sum width (N1+N2 of the upstream hybrid adder).
REQ-002 The block SHALL provide parameter CNT_W, default 16, giving the sample-counter width.
REQ-003 clk  input  1  the single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  begin a measurement run; sampled in IDLE and DONE only.
REQ-006 num_samples  input  CNT_W  run length, captured on accepted start.
REQ-007 in_valid  input  1  approx_sum/exact_sum pair present.
REQ-008 in_ready  output  1  block accepts a pair this cycle.
REQ-009 approx_sum  input  W  signed result from the approximate adder under test.
REQ-010 exact_sum  input  W  signed golden result for the same operands.
REQ-011 busy  output  1  high in RUN.
REQ-012 done  output  1  high in DONE; results are valid.
REQ-013 err_count  output  CNT_W  number of pairs with approx_sum != exact_sum.
REQ-014 ed_sum  output  W+1+CNT_W  sum of error distances over the run.
REQ-015 max_ed  output  W+1  largest error distance seen in the run.

Function
REQ-016 The error distance SHALL be |approx_sum - exact_sum|, with both operands sign-extended to W+1 bits, as a W+1-bit unsigned magnitude that never wraps.
REQ-017 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-018 In IDLE or DONE, start=1 with num_samples!=0 SHALL clear all results, load the remaining counter and enter RUN on the next edge.
REQ-019 In IDLE or DONE, start=1 with num_samples==0 SHALL clear all results and enter DONE on the next edge.
REQ-020 in_ready SHALL equal 1 exactly when the state is RUN; in_valid outside RUN SHALL be ignored.
REQ-021 Each edge with in_valid&in_ready SHALL update err_count, ed_sum and max_ed on that edge and decrement the remaining counter.
REQ-022 When the accepted pair is the last one (remaining==1), the FSM SHALL enter DONE on the same edge, so done rises together with the final result update, with zero extra latency.
REQ-023 start during RUN SHALL be ignored.
REQ-024 done SHALL stay high, and results SHALL be held, until the next accepted start or rst.
REQ-025 ed_sum SHALL never overflow, since its width covers 2^CNT_W-1 samples at the maximum ED.
REQ-026 Equal inputs SHALL contribute 0 to ed_sum and SHALL NOT increment err_count.

Reset
REQ-027 rst SHALL force the following immediately, regardless of edge, including mid-run: state IDLE; busy=0, done=0, in_ready=0; err_count, ed_sum, max_ed and the remaining counter all 0.
REQ-028 After rst deasserts, the block SHALL wait for start; no partial run SHALL resume.

Configuration
REQ-029 Macro APPROX_ERR_MAX_TRACK_EN SHALL, when defined, compile in the max_ed register and its compare logic.
REQ-030 When APPROX_ERR_MAX_TRACK_EN is undefined, max_ed SHALL be constant 0 with no register inferred, and all other behaviour SHALL be unchanged.

Structure
REQ-031 Package approx_err_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the default W/CNT_W constants.
REQ-032 Sub-module approx_ed_calc SHALL hold the combinational W+1-bit sign-extended subtract and absolute value, and SHALL be instantiated once.

Verification
REQ-033 Reset: assert rst mid-cycle -> all outputs 0 immediately; in_ready=0.
REQ-034 num_samples=3 with pairs (100,100), (100,96), (-5,3) -> done rises on the third accept edge; err_count=2, ed_sum=12, max_ed=8.
REQ-035 Extreme case: num_samples=1, approx=0x7FFFFFFF, exact=0x80000000 -> ed_sum=max_ed=0xFFFFFFFF (33-bit value), err_count=1, no wrap.
REQ-036 num_samples=0 with start -> done=1 on the next edge; all results 0; in_ready never 1.
REQ-037 Reset mid-run: accept 1 of 3 pairs, pulse rst -> IDLE with zeroed results; later in_valid pairs are ignored until the next start.
REQ-038 Run with APPROX_ERR_MAX_TRACK_EN undefined using the REQ-034 stimulus -> max_ed=0; err_count and ed_sum identical to REQ-034.

Source files
------------

// File: rtl/approx_err_pkg.sv
// Shared FSM state type and default widths for the approximate-adder error monitor.
package approx_err_pkg;
   localparam int W_DEF     = 32;
   localparam int CNT_W_DEF = 16;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/approx_ed_calc.sv
// Error distance |approx - exact|, computed one bit wider than the operands so it never wraps.
module approx_ed_calc #(
   parameter int W = 32
) (
   input  logic [W-1:0] approx_sum,
   input  logic [W-1:0] exact_sum,
   output logic [W:0]   ed
);
   logic signed [W:0] diff;

   // sign-extended subtract; the magnitude of a W+1-bit difference of W-bit values always fits W+1 unsigned bits
   assign diff = $signed({approx_sum[W-1], approx_sum}) - $signed({exact_sum[W-1], exact_sum});
   assign ed   = diff[W] ? $unsigned(-diff) : $unsigned(diff);
endmodule

// File: rtl/approx_error_monitor.sv
// Measures error count, summed error distance and peak error distance over a run of num_samples pairs.
// Define APPROX_ERR_MAX_TRACK_EN to build the max_ed tracker; otherwise max_ed is tied to 0.
module approx_error_monitor
   import approx_err_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [CNT_W-1:0]     num_samples,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [W-1:0]         approx_sum,
   input  logic [W-1:0]         exact_sum,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_W-1:0]     err_count,
   output logic [W+CNT_W:0]     ed_sum,
   output logic [W:0]           max_ed
);
   state_t           state;
   logic [CNT_W-1:0] remaining;
   logic [W:0]       ed;
   logic             accept;
   logic             launch;

   approx_ed_calc #(.W(W)) u_ed (
      .approx_sum (approx_sum),
      .exact_sum  (exact_sum),
      .ed         (ed)
   );

   assign in_ready = (state == RUN);
   assign busy     = (state == RUN);
   assign done     = (state == DONE);
   assign accept   = in_valid && (state == RUN);
   assign launch   = start && (state != RUN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         remaining <= '0;
         err_count <= '0;
         ed_sum    <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  err_count <= '0;
                  ed_sum    <= '0;
                  remaining <= num_samples;
                  state     <= (num_samples != '0) ? RUN : DONE;
               end
            end
            RUN: begin
               if (accept) begin
                  if (approx_sum != exact_sum) err_count <= err_count + 1'b1;
                  ed_sum    <= ed_sum + {{CNT_W{1'b0}}, ed};
                  remaining <= remaining - 1'b1;
                  // last pair: results and done land on the same edge
                  if (remaining == CNT_W'(1)) state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef APPROX_ERR_MAX_TRACK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         max_ed <= '0;
      else if (launch)
         max_ed <= '0;
      else if (accept && (ed > max_ed))
         max_ed <= ed;
   end
`else
   assign max_ed = '0;
`endif
endmodule

// File: tb/tb_approx_error_monitor.sv
// Randomized self-checking bench for approx_error_monitor against an arithmetic reference model.
module tb_approx_error_monitor;
   localparam int W     = 32;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic [CNT_W-1:0] num_samples = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [W-1:0]     approx_sum = '0;
   logic [W-1:0]     exact_sum = '0;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] err_count;
   logic [W+CNT_W:0] ed_sum;
   logic [W:0]       max_ed;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: plain run bookkeeping
   bit     m_run = 0;
   bit     m_done = 0;
   int     m_rem = 0;
   longint m_err = 0;
   longint m_ed = 0;
   longint m_max = 0;

   approx_error_monitor #(.W(W), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .num_samples (num_samples),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .approx_sum  (approx_sum),
      .exact_sum   (exact_sum),
      .busy        (busy),
      .done        (done),
      .err_count   (err_count),
      .ed_sum      (ed_sum),
      .max_ed      (max_ed)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic longint edist(input logic [W-1:0] a, input logic [W-1:0] b);
      longint d;
      d = longint'($signed(a)) - longint'($signed(b));
      return (d < 0) ? -d : d;
   endfunction

   function automatic longint exp_max();
`ifdef APPROX_ERR_MAX_TRACK_EN
      return m_max;
`else
      return 0;
`endif
   endfunction

   task automatic chk_all(input string tag);
      chk({tag, ".busy"},  longint'(busy),      longint'(m_run));
      chk({tag, ".rdy"},   longint'(in_ready),  longint'(m_run));
      chk({tag, ".done"},  longint'(done),      longint'(m_done));
      chk({tag, ".err"},   longint'(err_count), m_err);
      chk({tag, ".edsum"}, longint'(ed_sum),    m_ed);
      chk({tag, ".max"},   longint'(max_ed),    exp_max());
   endtask

   task automatic do_start(input int n, input string tag);
      @(negedge clk);
      start = 1'b1;
      num_samples = CNT_W'(n);
      @(posedge clk);
      #1;
      start = 1'b0;
      if (!m_run) begin
         m_err = 0; m_ed = 0; m_max = 0;
         m_rem = n;
         m_run = (n != 0);
         m_done = (n == 0);
      end
      chk_all(tag);
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
      longint d;
      @(negedge clk);
      in_valid = 1'b1;
      approx_sum = a;
      exact_sum = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (m_run) begin
         d = edist(a, b);
         if (a != b) m_err++;
         m_ed += d;
         if (d > m_max) m_max = d;
         m_rem--;
         if (m_rem == 0) begin
            m_run = 0;
            m_done = 1;
         end
      end
      chk_all(tag);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         approx_sum = $urandom;
         exact_sum = $urandom;
      end
   endtask

   function automatic logic [W-1:0] rnd_val(input int sel);
      case (sel)
         0: return 32'h7FFF_FFFF;
         1: return 32'h8000_0000;
         2: return W'($urandom_range(0, 20)) - 32'd10;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [W-1:0] a, b;
      int n;

      rst = 1'b1;
      #12 rst = 1'b0;
      chk_all("reset");

      // 3-pair directed run: one equal, ED 4 and ED 8
      do_start(3, "d3.start");
      send(32'd100, 32'd100, "d3.p0");
      send(32'd100, 32'd96, "d3.p1");
      send(-32'sd5, 32'd3, "d3.p2");
      chk("d3.err_val", longint'(err_count), 2);
      chk("d3.ed_val", longint'(ed_sum), 12);
      idle(3);
      #1 chk_all("d3.hold");

      // extreme opposite-sign operands: 33-bit ED, no wrap
      do_start(1, "ext.start");
      send(32'h7FFF_FFFF, 32'h8000_0000, "ext.p0");
      chk("ext.ed_val", longint'(ed_sum), 64'hFFFF_FFFF);

      // zero-length run clears results and goes straight to done
      do_start(0, "zero.start");
      send(32'd1, 32'd2, "zero.ign");

      // start while running is ignored
      do_start(3, "sr.start");
      send(32'd7, 32'd1, "sr.p0");
      do_start(1, "sr.restart");
      send(32'd2, 32'd9, "sr.p1");
      send(32'd5, 32'd5, "sr.p2");

      // reset mid-run: accept 1 of 3, reset between edges
      do_start(3, "rr.start");
      send(32'd50, 32'd10, "rr.p0");
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      m_run = 0; m_done = 0; m_rem = 0; m_err = 0; m_ed = 0; m_max = 0;
      chk_all("rr.rst");
      #3 rst = 1'b0;
      for (int i = 0; i < 3; i++) send($urandom, $urandom, "rr.ign");

      // randomized runs with idle gaps and occasional equal / extreme pairs
      for (int r = 0; r < 25; r++) begin
         n = $urandom_range(1, 8);
         do_start(n, "rnd.start");
         while (m_run) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            a = rnd_val($urandom_range(0, 5));
            b = ($urandom_range(0, 3) == 0) ? a : rnd_val($urandom_range(0, 5));
            send(a, b, "rnd.p");
         end
         send($urandom, $urandom, "rnd.post");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
